// File: rtl/hash_seq_ctrl_if.sv
// rtl/hash_seq_ctrl_if.sv - word-in, core and hash-out handshake bundle for hash_seq_ctrl
interface hash_seq_ctrl_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        in_last;
  logic [1:0]  core_start;
  logic [31:0] core_data;
  logic [2:0]  core_finished;
  logic [31:0] core_hash;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_hash;
  logic        busy;
  logic        error;

  modport slave (
    input  in_valid, in_data, in_last, core_finished, core_hash, out_ready,
    output in_ready, core_start, core_data, out_valid, out_hash, busy, error
  );

  modport master (
    output in_valid, in_data, in_last, core_finished, core_hash, out_ready,
    input  in_ready, core_start, core_data, out_valid, out_hash, busy, error
  );
endinterface

// File: rtl/hash_seq_ctrl.sv
// rtl/hash_seq_ctrl.sv - buffers one message block, drives the hash core and returns its result
module hash_seq_ctrl #(
  parameter int WORDS   = 16,
  parameter int TIMEOUT = 1023
) (
  input logic           clk,
  input logic           reset,
  hash_seq_ctrl_if.slave bus
);

  localparam int IW = $clog2(WORDS);
  localparam int WW = $clog2(TIMEOUT + 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(WORDS - 1);
  localparam logic [WW-1:0] WD_MAX   = WW'(TIMEOUT);
  localparam logic [1:0] CS_IDLE = 2'b00;
  localparam logic [1:0] CS_REQ  = 2'b01;
  localparam logic [1:0] CS_DATA = 2'b10;
  localparam logic [2:0] FIN_ACK  = 3'b001;
  localparam logic [2:0] FIN_DONE = 3'b010;

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_START, S_DATA, S_WAIT, S_RESULT, S_ERR
  } state_t;

  state_t        state;
  logic [IW-1:0] idx;
  logic [IW-1:0] idx_nxt;
  logic [WW-1:0] wd;
  logic [31:0]   mem [WORDS];
  logic          ld_fire;
  logic          ld_end;

  assign idx_nxt = idx + 1'b1;
  assign ld_fire = (state == S_LOAD) && bus.in_valid && bus.in_ready;
  assign ld_end  = ld_fire && (bus.in_last || idx == LAST_IDX);

  // Slots above the final word are cleared so a short block never carries stale data.
  always_ff @(posedge clk) begin
    for (int i = 0; i < WORDS; i++) begin
      if (ld_fire && i == int'(idx))
        mem[i] <= bus.in_data;
      else if (ld_end && i > int'(idx))
        mem[i] <= '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= S_IDLE;
      idx            <= '0;
      wd             <= '0;
      bus.in_ready   <= 1'b0;
      bus.core_start <= CS_IDLE;
      bus.core_data  <= '0;
      bus.out_valid  <= 1'b0;
      bus.out_hash   <= '0;
      bus.busy       <= 1'b0;
      bus.error      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.in_valid) begin
            state        <= S_LOAD;
            bus.in_ready <= 1'b1;
            bus.busy     <= 1'b1;
          end
        end
        S_LOAD: begin
          if (ld_fire) begin
            if (ld_end) begin
              state          <= S_START;
              idx            <= '0;
              wd             <= '0;
              bus.in_ready   <= 1'b0;
              bus.core_start <= CS_REQ;
            end else begin
              idx <= idx_nxt;
            end
          end
        end
        S_START: begin
          if (bus.core_finished == FIN_ACK) begin
            state          <= S_DATA;
            wd             <= '0;
            idx            <= '0;
            bus.core_start <= CS_DATA;
            bus.core_data  <= mem[0];
          end else if (wd == WD_MAX) begin
            state          <= S_ERR;
            bus.error      <= 1'b1;
            bus.core_start <= CS_IDLE;
          end else begin
            wd <= wd + 1'b1;
          end
        end
        S_DATA: begin
          // idx tracks the word currently on core_data.
          if (idx == LAST_IDX) begin
            state          <= S_WAIT;
            idx            <= '0;
            wd             <= '0;
            bus.core_start <= CS_IDLE;
            bus.core_data  <= '0;
          end else begin
            idx           <= idx_nxt;
            bus.core_data <= mem[idx_nxt];
          end
        end
        S_WAIT: begin
          // Done is tested before the watchdog so a last-cycle result still wins.
          if (bus.core_finished == FIN_DONE) begin
            state         <= S_RESULT;
            bus.out_hash  <= bus.core_hash;
            bus.out_valid <= 1'b1;
          end else if (wd == WD_MAX) begin
            state     <= S_ERR;
            bus.error <= 1'b1;
          end else begin
            wd <= wd + 1'b1;
          end
        end
        S_RESULT: begin
          if (bus.out_ready) begin
            state         <= S_IDLE;
            bus.out_valid <= 1'b0;
            bus.busy      <= 1'b0;
          end
        end
        S_ERR: begin
          bus.error      <= 1'b1;
          bus.busy       <= 1'b1;
          bus.in_ready   <= 1'b0;
          bus.core_start <= CS_IDLE;
          bus.core_data  <= '0;
          bus.out_valid  <= 1'b0;
          bus.out_hash   <= '0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hash_seq_ctrl.sv
// tb/tb_hash_seq_ctrl.sv - directed vector bench for hash_seq_ctrl
module tb_hash_seq_ctrl;
  localparam int WORDS   = 16;
  localparam int TIMEOUT = 1023;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  hash_seq_ctrl_if bus ();

  hash_seq_ctrl #(.WORDS(WORDS), .TIMEOUT(TIMEOUT)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [7:0]        nw;
    logic              use_last;
    logic [7:0]        ack_dly;
    logic [7:0]        bp;
    logic [31:0]       hash;
    logic [15:0][31:0] w;
    logic [15:0][31:0] exp;
  } vec_t;

  vec_t vecs [4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic load_words(input vec_t v);
    int t;
    bus.in_valid = 1'b1;
    bus.in_data  = v.w[0];
    bus.in_last  = 1'b0;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!bus.in_ready && t < 10);
    chk("in_ready_rise", {31'b0, bus.in_ready}, 32'd1);
    for (int k = 0; k < int'(v.nw); k++) begin
      bus.in_data = v.w[k];
      bus.in_last = v.use_last && (k == int'(v.nw) - 1);
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    chk("start_latency", {30'b0, bus.core_start}, 32'd1);
    chk("in_ready_after_load", {31'b0, bus.in_ready}, 32'd0);
  endtask

  task automatic start_ack(input int dly, input bit spurious);
    for (int d = 0; d < dly; d++) begin
      if (spurious && d == 0) bus.core_finished = 3'b010;
      @(negedge clk);
      bus.core_finished = 3'b000;
      chk(spurious && d == 0 ? "spurious_done_in_start" : "start_hold",
          {30'b0, bus.core_start}, 32'd1);
    end
    bus.core_finished = 3'b001;
    @(negedge clk);
    bus.core_finished = 3'b000;
  endtask

  task automatic stream(input vec_t v);
    for (int j = 0; j < WORDS; j++) begin
      chk("data_phase", {30'b0, bus.core_start}, 32'd2);
      chk("core_data", bus.core_data, v.exp[j]);
      @(negedge clk);
    end
    chk("wait_core_start", {30'b0, bus.core_start}, 32'd0);
  endtask

  task automatic finish_block(input logic [31:0] h, input int bp);
    bus.core_finished = 3'b010;
    bus.core_hash     = h;
    @(negedge clk);
    bus.core_finished = 3'b000;
    bus.core_hash     = ~h;
    chk("out_valid", {31'b0, bus.out_valid}, 32'd1);
    chk("out_hash", bus.out_hash, h);
    chk("busy_in_result", {31'b0, bus.busy}, 32'd1);
    bus.in_valid = 1'b1;
    for (int b = 0; b < bp; b++) begin
      @(negedge clk);
      chk("bp_out_valid", {31'b0, bus.out_valid}, 32'd1);
      chk("bp_out_hash", bus.out_hash, h);
      chk("bp_in_ready", {31'b0, bus.in_ready}, 32'd0);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    chk("out_valid_drop", {31'b0, bus.out_valid}, 32'd0);
    chk("busy_idle", {31'b0, bus.busy}, 32'd0);
  endtask

  task automatic run_block(input vec_t v);
    load_words(v);
    start_ack(int'(v.ack_dly), 1'b0);
    stream(v);
    finish_block(v.hash, int'(v.bp));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1);
  end

  initial begin
    int t;
    bus.in_valid      = 1'b0;
    bus.in_data       = '0;
    bus.in_last       = 1'b0;
    bus.core_finished = 3'b000;
    bus.core_hash     = '0;
    bus.out_ready     = 1'b0;
    reset             = 1'b1;

    for (int v = 0; v < 4; v++) vecs[v] = '0;
    for (int i = 0; i < 16; i++) begin
      vecs[0].w[i]   = 32'(i);
      vecs[0].exp[i] = 32'(i);
      vecs[3].w[i]   = 32'h100 + 32'(i);
      vecs[3].exp[i] = 32'h100 + 32'(i);
    end
    vecs[0].nw = 8'd16; vecs[0].use_last = 1'b1; vecs[0].ack_dly = 8'd2; vecs[0].hash = 32'h0123_4567;
    vecs[1].nw = 8'd3;  vecs[1].use_last = 1'b1; vecs[1].ack_dly = 8'd0; vecs[1].hash = 32'h89AB_CDEF;
    vecs[1].w[0] = 32'hA; vecs[1].w[1] = 32'hB; vecs[1].w[2] = 32'hC;
    vecs[1].exp[0] = 32'hA; vecs[1].exp[1] = 32'hB; vecs[1].exp[2] = 32'hC;
    vecs[2].nw = 8'd1;  vecs[2].use_last = 1'b1; vecs[2].ack_dly = 8'd5; vecs[2].hash = 32'h5A5A_0001;
    vecs[2].bp = 8'd5;
    vecs[2].w[0] = 32'hDEAD_BEEF; vecs[2].exp[0] = 32'hDEAD_BEEF;
    vecs[3].nw = 8'd16; vecs[3].use_last = 1'b0; vecs[3].ack_dly = 8'd1; vecs[3].hash = 32'hCAFE_F00D;

    @(negedge clk);
    chk("rst_in_ready", {31'b0, bus.in_ready}, 32'd0);
    chk("rst_core_start", {30'b0, bus.core_start}, 32'd0);
    chk("rst_core_data", bus.core_data, 32'd0);
    chk("rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
    chk("rst_out_hash", bus.out_hash, 32'd0);
    chk("rst_busy", {31'b0, bus.busy}, 32'd0);
    chk("rst_error", {31'b0, bus.error}, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    for (int v = 0; v < 4; v++) run_block(vecs[v]);

    // Watchdog: core never acknowledges the start request.
    load_words(vecs[1]);
    t = 0;
    while (!bus.error && t < TIMEOUT + 100) begin
      @(negedge clk);
      t++;
    end
    chk("wd_window", {31'b0, (t >= TIMEOUT && t <= TIMEOUT + 1)}, 32'd1);
    chk("err_flag", {31'b0, bus.error}, 32'd1);
    chk("err_core_start", {30'b0, bus.core_start}, 32'd0);
    chk("err_busy", {31'b0, bus.busy}, 32'd1);
    bus.core_finished = 3'b001;
    bus.in_valid      = 1'b1;
    repeat (3) @(negedge clk);
    chk("err_sticky", {31'b0, bus.error}, 32'd1);
    chk("err_in_ready", {31'b0, bus.in_ready}, 32'd0);
    chk("err_core_start_hold", {30'b0, bus.core_start}, 32'd0);
    bus.core_finished = 3'b000;
    bus.in_valid      = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    chk("err_cleared", {31'b0, bus.error}, 32'd0);
    chk("err_busy_cleared", {31'b0, bus.busy}, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Reset while word 7 is on the core bus, then a short block must see no stale words.
    load_words(vecs[0]);
    start_ack(0, 1'b0);
    for (int j = 0; j < 8; j++) begin
      chk("midrun_data", bus.core_data, vecs[0].exp[j]);
      if (j < 7) @(negedge clk);
    end
    reset = 1'b1;
    #1;
    chk("midrun_core_start", {30'b0, bus.core_start}, 32'd0);
    chk("midrun_busy", {31'b0, bus.busy}, 32'd0);
    chk("midrun_out_valid", {31'b0, bus.out_valid}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    run_block(vecs[1]);

    // Spurious codes, then done landing on the final watchdog cycle.
    load_words(vecs[1]);
    start_ack(2, 1'b1);
    stream(vecs[1]);
    bus.core_finished = 3'b001;
    for (int k = 1; k <= TIMEOUT; k++) begin
      @(negedge clk);
      bus.core_finished = 3'b000;
      if (k == 1) begin
        chk("spurious_ack_in_wait", {30'b0, bus.core_start}, 32'd0);
        chk("spurious_ack_out_valid", {31'b0, bus.out_valid}, 32'd0);
      end
    end
    chk("wait_last_busy", {31'b0, bus.busy}, 32'd1);
    chk("wait_last_error", {31'b0, bus.error}, 32'd0);
    finish_block(32'h7777_0001, 0);
    chk("done_wins_error", {31'b0, bus.error}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
